// File: rtl/ex_pkg.sv
// Shared types for the RV32 execute stage: ALU op codes, FSM states, PC step.
package ex_pkg;

  typedef enum logic [3:0] {
    OP_AND  = 4'd0,
    OP_OR   = 4'd1,
    OP_ADD  = 4'd2,
    OP_XOR  = 4'd3,
    OP_NOR  = 4'd4,
    OP_SRL  = 4'd5,
    OP_SUB  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLTU = 4'd10,
    OP_MUL  = 4'd11
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } ex_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ex_alu.sv
// Combinational single-cycle ALU. MUL and codes 12-15 produce 0 here;
// the multi-cycle multiply lives in the stage.
module ex_alu
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  alu_op_e         op_i,
  output logic [XLEN-1:0] res_o,
  output logic            zero_o
);

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_ADD:  res_o = a_i + b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_SRL:  res_o = a_i >> shamt;
      OP_SUB:  res_o = a_i - b_i;
      OP_SLT:  res_o = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLL:  res_o = a_i << shamt;
      OP_SRA:  res_o = XLEN'($signed(a_i) >>> shamt);
      OP_SLTU: res_o = {{(XLEN-1){1'b0}}, (a_i < b_i)};
      default: res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule

// File: rtl/pipeline_ex_stage.sv
// RV32 execute stage with registered EX/MEM output (valid/ready) and flush.
// Define EX_MUL_EN to add the iterative shift-add multiplier (op 11).
module pipeline_ex_stage
  import ex_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [3:0]      alu_op_in,
  input  logic            alusrc_b_in,
  input  logic [RD_W-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc4_out,
  output logic [XLEN-1:0] target_out,
  output logic [XLEN-1:0] alu_out,
  output logic            zero_out,
  output logic [XLEN-1:0] rs2_out,
  output logic [RD_W-1:0] rd_out,
  output logic            busy,
  output ex_state_e       dbg_state
);

  // Handshake: an instruction is consumed on a rising edge where
  // in_valid && in_ready; a result is consumed where out_valid && out_ready.
  // Producers hold their payload stable until it is consumed.

  logic [XLEN-1:0] b_sel, pc4, target, alu_res;
  logic            alu_zero, accept, is_mul, mul_done;
  logic [XLEN-1:0] mul_res;
  ex_state_e       state_q;

  logic            out_valid_q, zero_q;
  logic [XLEN-1:0] pc4_q, target_q, alu_q, rs2_q;
  logic [RD_W-1:0] rd_q;

  assign b_sel  = alusrc_b_in ? imm_in : rs2_in;
  assign pc4    = pc_in + XLEN'(PC_STEP);
  assign target = pc_in + imm_in;
  assign accept = in_valid && in_ready;

  ex_alu #(.XLEN(XLEN), .SHW(SHW)) u_alu (
    .a_i    (rs1_in),
    .b_i    (b_sel),
    .op_i   (alu_op_e'(alu_op_in)),
    .res_o  (alu_res),
    .zero_o (alu_zero)
  );

`ifdef EX_MUL_EN
  ex_state_e       state_d;
  logic [SHW-1:0]  cnt_q;
  logic [XLEN-1:0] mul_a_q, mul_b_q, acc_q, acc_d;

  assign is_mul   = (alu_op_in == 4'(OP_MUL));
  assign mul_done = (state_q == MUL) && (cnt_q == SHW'(XLEN-1));
  assign acc_d    = acc_q + (mul_b_q[0] ? mul_a_q : '0);
  assign mul_res  = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mul) state_d = MUL;
      MUL:     if (mul_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // Step i adds A<<i when bit i of B is set; A shifts left, B shifts right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      acc_q   <= '0;
    end else if (flush) begin
      cnt_q <= '0;
    end else if (accept && is_mul) begin
      cnt_q   <= '0;
      mul_a_q <= rs1_in;
      mul_b_q <= b_sel;
      acc_q   <= '0;
    end else if (state_q == MUL) begin
      cnt_q   <= cnt_q + 1'b1;
      mul_a_q <= mul_a_q << 1;
      mul_b_q <= mul_b_q >> 1;
      acc_q   <= acc_d;
    end
  end
`else
  assign state_q  = IDLE;
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_res  = '0;
`endif

  always_comb begin
    busy     = (state_q == MUL);
    in_ready = !rst && !flush && (state_q == IDLE) && (!out_valid_q || out_ready);
  end

  // A multiply parks its side-band fields in the output register at accept;
  // out_valid is low until the product lands, so nothing downstream sees them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      pc4_q       <= '0;
      target_q    <= '0;
      alu_q       <= '0;
      zero_q      <= 1'b0;
      rs2_q       <= '0;
      rd_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= !is_mul;
      pc4_q       <= pc4;
      target_q    <= target;
      rs2_q       <= rs2_in;
      rd_q        <= rd_in;
      if (!is_mul) begin
        alu_q  <= alu_res;
        zero_q <= alu_zero;
      end
    end else if (mul_done) begin
      out_valid_q <= 1'b1;
      alu_q       <= mul_res;
      zero_q      <= (mul_res == '0);
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign pc4_out    = pc4_q;
  assign target_out = target_q;
  assign alu_out    = alu_q;
  assign zero_out   = zero_q;
  assign rs2_out    = rs2_q;
  assign rd_out     = rd_q;
  assign dbg_state  = state_q;

endmodule
